// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: matrix size, key map, FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } key_state_t;

  // Hex code for each switch, indexed by frame bit c*4+r.
  // Columns in order: c0 = 1 4 7 E, c1 = 2 5 8 0, c2 = 3 6 9 F, c3 = A B C D.
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h4, 4'h7, 4'hE,
    4'h2, 4'h5, 4'h8, 4'h0,
    4'h3, 4'h6, 4'h9, 4'hF,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  // True when exactly one switch is closed in the frame.
  function automatic logic is_single(input logic [15:0] f);
    return (f != 16'h0000) && ((f & (f - 16'd1)) == 16'h0000);
  endfunction

  // Position of the (single) set bit; only meaningful when is_single() holds.
  function automatic logic [3:0] bit_index(input logic [15:0] f);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (f[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_frame_filter.sv
// Assembles per-column row samples into 16-bit frames and debounces whole frames.
// Latency: frame_accept pulses 1 cycle after the column-3 sample of the accepting frame.
// Backpressure: none; a frame is produced every scan and must be consumed on the pulse.
//
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   sample        last dwell cycle of the current column
//   col           column currently driven
//   row_bits      synchronized active-high row levels
//   frame_accept  one-cycle pulse when the frame has been stable long enough
//   frame         most recent complete frame (bit c*4+r)
module keypad_frame_filter
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample,
  input  logic [1:0]           col,
  input  logic [ROWS-1:0]      row_bits,
  output logic                 frame_accept,
  output logic [ROWS*COLS-1:0] frame
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

  logic [CW-1:0]               stable_cnt;
  logic [ROWS*(COLS-1)-1:0]    partial;
  logic [ROWS*COLS-1:0]        full_frame;
  logic                        frame_done;

  // Column 3 samples go straight into the compare, so only columns 0..2 are buffered.
  assign full_frame = {row_bits, partial};
  assign frame_done = sample && (col == 2'(COLS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      partial      <= '0;
      frame        <= '0;
      stable_cnt   <= '0;
      frame_accept <= 1'b0;
    end else begin
      frame_accept <= 1'b0;
      if (sample) begin
        case (col)
          2'd0:    partial[3:0]  <= row_bits;
          2'd1:    partial[7:4]  <= row_bits;
          2'd2:    partial[11:8] <= row_bits;
          default: ;
        endcase
      end
      if (frame_done) begin
        frame <= full_frame;
        if (full_frame == frame) begin
          // Saturate so a long steady frame is accepted once, not every scan.
          if (stable_cnt != CW'(DEBOUNCE_FRAMES)) begin
            stable_cnt <= stable_cnt + CW'(1);
          end
          frame_accept <= (stable_cnt == CW'(DEBOUNCE_FRAMES - 1));
        end else begin
          stable_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row sync, frame debounce, single-key encode to hex.
// Latency: press reported 1 cycle after frame acceptance; worst case (DEBOUNCE_FRAMES+2)*4*COL_DWELL+3.
// Backpressure: valid/ack register; a press arriving while unacked is dropped and flags key_overrun.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   rows         keypad rows, active-low, asynchronous
//   cols         column drive, active-low, one-cold
//   key_code     hex code of the last accepted key
//   key_valid    key_code holds an unacknowledged press
//   key_ack      consumer acknowledge, effective only while key_valid
//   key_held     accepted key still held down
//   key_overrun  sticky: a press was dropped while key_valid was pending
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int COL_DWELL       = 50_000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ROWS-1:0] rows,
  output logic [COLS-1:0] cols,
  output logic [3:0]      key_code,
  output logic            key_valid,
  input  logic            key_ack,
  output logic            key_held,
  output logic            key_overrun
);

  localparam int DW = $clog2(COL_DWELL);

  logic [ROWS-1:0]      sync1;
  logic [ROWS-1:0]      sync2;
  logic [1:0]           col_idx;
  logic [DW-1:0]        dwell_cnt;
  logic                 dwell_last;
  logic                 frame_accept;
  logic [ROWS*COLS-1:0] frame;
  logic                 press_evt;
  key_state_t           state;

  // Two-flop synchronizer; resets to "all released" (pulled-up rows).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= rows;
      sync2 <= sync1;
    end
  end

  assign dwell_last = (dwell_cnt == DW'(COL_DWELL - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      col_idx   <= 2'd0;
      dwell_cnt <= '0;
    end else if (dwell_last) begin
      dwell_cnt <= '0;
      col_idx   <= col_idx + 2'd1;
    end else begin
      dwell_cnt <= dwell_cnt + DW'(1);
    end
  end

  assign cols = ~(COLS'(1) << col_idx);

  // Sampling at the end of the dwell leaves the synchronizer time to settle on the new column.
  keypad_frame_filter #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_filter (
    .clk          (clk),
    .reset        (reset),
    .sample       (dwell_last),
    .col          (col_idx),
    .row_bits     (~sync2),
    .frame_accept (frame_accept),
    .frame        (frame)
  );

  // Multi-key frames are ignored in IDLE, which also rejects ghost patterns.
  assign press_evt = frame_accept && (state == IDLE) && is_single(frame);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      key_held    <= 1'b0;
      key_code    <= 4'h0;
      key_valid   <= 1'b0;
      key_overrun <= 1'b0;
    end else begin
      if (frame_accept) begin
        case (state)
          IDLE: if (is_single(frame)) begin
            state    <= HELD;
            key_held <= 1'b1;
          end
          HELD: if (frame == '0) begin
            state    <= IDLE;
            key_held <= 1'b0;
          end
        endcase
      end

      if (press_evt) begin
        if (!key_valid || key_ack) begin
          key_code    <= KEYMAP[bit_index(frame)];
          key_valid   <= 1'b1;
          key_overrun <= 1'b0;
        end else begin
          key_overrun <= 1'b1;
        end
      end else if (key_valid && key_ack) begin
        key_valid   <= 1'b0;
        key_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam int CD    = 4;
  localparam int DB    = 2;
  localparam int FRAME = 4 * CD;
  localparam int LAT   = (DB + 2) * 4 * CD + 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_ack;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic        key_overrun;
  logic [15:0] pressed;   // bit c*4+r = switch (r,c) closed

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Passive matrix: a row is pulled low when a closed switch sits on a driven column.
  always_comb begin
    rows = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (pressed[c*4+r] && !cols[c]) rows[r] = 1'b0;
      end
    end
  end

  keypad_scanner #(
    .COL_DWELL       (CD),
    .DEBOUNCE_FRAMES (DB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rows        (rows),
    .cols        (cols),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ack     (key_ack),
    .key_held    (key_held),
    .key_overrun (key_overrun)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // sel: 0 = key_valid, 1 = key_held, 2 = key_overrun
  task automatic wait_for(input int sel, input logic level, input int budget, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (n < budget && !ok) begin
      tick();
      n++;
      case (sel)
        0:       ok = (key_valid === level);
        1:       ok = (key_held === level);
        default: ok = (key_overrun === level);
      endcase
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_cols;
    reset   = 1'b1;
    key_ack = 1'b0;
    pressed = 16'h0000;
    repeat (3) tick();
    total++; if (cols !== 4'b1110) begin bad++; $display("FAIL reset_cols: got %b want 1110", cols); end
    total++; if (key_code !== 4'h0) begin bad++; $display("FAIL reset_code: got %h want 0", key_code); end
    total++; if ({key_valid, key_held, key_overrun} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b want 000", {key_valid, key_held, key_overrun});
    end
    reset = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      exp_cols = ~(4'b0001 << ((k / 4) % 4));
      total++; if (cols !== exp_cols) begin bad++; $display("FAIL scan_cols k=%0d: got %b want %b", k, cols, exp_cols); end
      total++; if ({key_valid, key_held, key_overrun} !== 3'b000) begin
        bad++; $display("FAIL idle_flags k=%0d: got %b want 000", k, {key_valid, key_held, key_overrun});
      end
    end
  endtask

  task automatic test_single_press();
    bit ok;
    int extra;
    pressed = 16'h0200;               // (r1,c2) -> 6
    wait_for(0, 1'b1, LAT, ok);
    total++; if (!ok) begin bad++; $display("FAIL press6_timeout: got key_valid=%b want 1 within %0d", key_valid, LAT); end
    total++; if (key_code !== 4'h6) begin bad++; $display("FAIL press6_code: got %h want 6", key_code); end
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL press6_held: got %b want 1", key_held); end
    total++; if (key_overrun !== 1'b0) begin bad++; $display("FAIL press6_ovr: got %b want 0", key_overrun); end
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL ack6_valid: got %b want 0", key_valid); end
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL ack6_held: got %b want 1", key_held); end
    pressed = 16'h0000;
    wait_for(1, 1'b0, LAT, ok);
    total++; if (!ok) begin bad++; $display("FAIL release6_timeout: got key_held=%b want 0 within %0d", key_held, LAT); end
    extra = 0;
    repeat (3 * FRAME) begin
      tick();
      if (key_valid !== 1'b0) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL release6_noevent: got %0d valid cycles want 0", extra); end
  endtask

  task automatic test_bounce();
    bit ok;
    int early;
    early = 0;
    for (int i = 0; i < 8; i++) begin
      pressed = (i % 2 == 0) ? 16'h0080 : 16'h0000;   // (r3,c1) -> 0
      repeat (5) begin
        tick();
        if (key_valid !== 1'b0 || key_held !== 1'b0) early++;
      end
    end
    total++; if (early !== 0) begin bad++; $display("FAIL bounce_early: got %0d event cycles want 0", early); end
    pressed = 16'h0080;
    wait_for(0, 1'b1, LAT, ok);
    total++; if (!ok) begin bad++; $display("FAIL bounce_timeout: got key_valid=%b want 1 within %0d", key_valid, LAT); end
    total++; if (key_code !== 4'h0) begin bad++; $display("FAIL bounce_code: got %h want 0", key_code); end
    repeat (3 * FRAME) tick();
    total++; if ({key_valid, key_held, key_overrun} !== 3'b110) begin
      bad++; $display("FAIL bounce_single: got v/h/o=%b want 110", {key_valid, key_held, key_overrun});
    end
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    pressed = 16'h0000;
    wait_for(1, 1'b0, LAT, ok);
    total++; if (!ok || key_valid !== 1'b0) begin
      bad++; $display("FAIL bounce_release: got held=%b valid=%b want 0 0", key_held, key_valid);
    end
  endtask

  task automatic test_ghost();
    bit ok;
    int evt;
    evt = 0;
    pressed = 16'h0021;               // keys 1 (r0,c0) and 5 (r1,c1)
    repeat (6 * FRAME) begin
      tick();
      if (key_valid !== 1'b0 || key_held !== 1'b0) evt++;
    end
    total++; if (evt !== 0) begin bad++; $display("FAIL two_keys_event: got %0d event cycles want 0", evt); end
    pressed = 16'h0001;
    wait_for(0, 1'b1, LAT, ok);
    total++; if (!ok) begin bad++; $display("FAIL key1_timeout: got key_valid=%b want 1 within %0d", key_valid, LAT); end
    total++; if (key_code !== 4'h1) begin bad++; $display("FAIL key1_code: got %h want 1", key_code); end
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    pressed = 16'h0000;
    wait_for(1, 1'b0, LAT, ok);
    total++; if (!ok) begin bad++; $display("FAIL key1_release: got key_held=%b want 0", key_held); end
  endtask

  task automatic test_overrun();
    bit ok;
    pressed = 16'h0100;               // (r0,c2) -> 3
    wait_for(0, 1'b1, LAT, ok);
    total++; if (!ok || key_code !== 4'h3) begin
      bad++; $display("FAIL key3: got valid=%b code=%h want 1 3", key_valid, key_code);
    end
    pressed = 16'h0000;
    wait_for(1, 1'b0, LAT, ok);
    total++; if (!ok) begin bad++; $display("FAIL key3_release: got key_held=%b want 0", key_held); end
    pressed = 16'h1000;               // (r0,c3) -> A
    wait_for(2, 1'b1, LAT, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovr_timeout: got key_overrun=%b want 1 within %0d", key_overrun, LAT); end
    total++; if (key_code !== 4'h3) begin bad++; $display("FAIL ovr_code: got %h want 3", key_code); end
    total++; if (key_valid !== 1'b1 || key_held !== 1'b1) begin
      bad++; $display("FAIL ovr_flags: got valid=%b held=%b want 1 1", key_valid, key_held);
    end
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
    total++; if ({key_valid, key_overrun} !== 2'b00) begin
      bad++; $display("FAIL ovr_ack: got valid/ovr=%b want 00", {key_valid, key_overrun});
    end
    pressed = 16'h0000;
    wait_for(1, 1'b0, LAT, ok);
    total++; if (!ok) begin bad++; $display("FAIL keyA_release: got key_held=%b want 0", key_held); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    pressed = 16'h0400;               // (r2,c2) -> 9
    wait_for(0, 1'b1, LAT, ok);
    total++; if (!ok || key_code !== 4'h9) begin
      bad++; $display("FAIL key9: got valid=%b code=%h want 1 9", key_valid, key_code);
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if ({cols, key_code, key_valid, key_held, key_overrun} !== {4'b1110, 4'h0, 3'b000}) begin
        bad++; $display("FAIL midreset_outs cyc=%0d: got cols=%b code=%h v/h/o=%b want 1110 0 000",
                        i, cols, key_code, {key_valid, key_held, key_overrun});
      end
    end
    reset = 1'b0;
    wait_for(0, 1'b1, LAT, ok);
    total++; if (!ok) begin bad++; $display("FAIL key9_again_timeout: got key_valid=%b want 1 within %0d", key_valid, LAT); end
    total++; if (key_code !== 4'h9 || key_held !== 1'b1) begin
      bad++; $display("FAIL key9_again: got code=%h held=%b want 9 1", key_code, key_held);
    end
  endtask

  initial begin
    reset   = 1'b1;
    key_ack = 1'b0;
    pressed = 16'h0000;
    @(negedge clk);
    test_reset();
    test_single_press();
    test_bounce();
    test_ghost();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
